// File: rtl/bw_clk_gl_vrt_seq.sv
// Staggered leaf clock-gate enable sequencer for the vertical clock spine; ramps one channel at a time.
// Optional: define BW_CLK_GL_VRT_SEQ_SYNC_EN to pass cken_req through a 2-flop synchroniser.
module bw_clk_gl_vrt_seq #(
    parameter int NCH   = 3,
    parameter int NLEAF = 8,
    parameter int GRP   = 2,
    parameter int DLYW  = 4
) (
    input  logic                   gclk,
    input  logic                   arst_l,
    input  logic [NCH-1:0]         cken_req,
    input  logic [DLYW-1:0]        step_dly,
    output logic [NCH*NLEAF-1:0]   leaf_en,
    output logic [NCH-1:0]         ch_on,
    output logic                   busy
);

    localparam int NSTEP = NLEAF / GRP;
    localparam int NW    = NCH * NLEAF;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int STW   = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [NW-1:0] GMASK = NW'({GRP{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DN} state_t;

    state_t          r_state, w_state_nxt;
    logic [CHW-1:0]  r_ptr, r_act, w_ptr_nxt, w_act_nxt, w_sel, w_ch;
    logic [STW-1:0]  r_step, w_step_nxt, w_grp;
    logic [DLYW-1:0] r_cnt, w_cnt_nxt;
    logic [NW-1:0]   r_leaf, w_leaf_nxt, w_mask;
    logic [NCH-1:0]  r_chon, w_chon_nxt, w_req, w_pend;
    logic            r_busy, w_wr, w_wr_on, w_fin;

`ifdef BW_CLK_GL_VRT_SEQ_SYNC_EN
    logic [NCH-1:0] r_req_s1, r_req_s2;

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            r_req_s1 <= '0;
            r_req_s2 <= '0;
        end else begin
            r_req_s1 <= cken_req;
            r_req_s2 <= r_req_s1;
        end
    end
    assign w_req = r_req_s2;
`else
    assign w_req = cken_req;
`endif

    // Round-robin search starting at the pointer; returns the first pending channel.
    function automatic logic [CHW-1:0] rr_pick(input logic [NCH-1:0] pend, input logic [CHW-1:0] ptr);
        logic [CHW-1:0] pick;
        logic           hit;
        int             idx;
        pick = ptr;
        hit  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!hit && pend[CHW'(idx)]) begin
                hit  = 1'b1;
                pick = CHW'(idx);
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_pend = w_req ^ r_chon;
        if (r_state != S_IDLE) w_pend[r_act] = 1'b0;
    end

    assign w_sel = rr_pick(w_pend, r_ptr);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_act_nxt   = r_act;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_chon_nxt  = r_chon;
        w_ch        = r_act;
        w_grp       = r_step;
        w_wr        = 1'b0;
        w_wr_on     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|w_pend) begin
                    w_ch      = w_sel;
                    w_act_nxt = w_sel;
                    w_cnt_nxt = step_dly;
                    w_wr      = 1'b1;
                    w_wr_on   = w_req[w_sel];
                    w_grp     = w_req[w_sel] ? '0 : STW'(NSTEP - 1);
                end
            end
            default: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Step event: direction follows the live request, so a reversal
                    // first undoes the group touched by the previous step.
                    w_cnt_nxt = step_dly;
                    w_wr      = 1'b1;
                    w_wr_on   = w_req[r_act];
                    if (w_req[r_act])
                        w_grp = (r_state == S_UP) ? STW'(int'(r_step) + 1) : r_step;
                    else
                        w_grp = (r_state == S_DN) ? STW'(int'(r_step) - 1) : r_step;
                end
            end
        endcase

        if (w_wr) begin
            w_step_nxt  = w_grp;
            w_state_nxt = w_wr_on ? S_UP : S_DN;
        end

        w_mask     = GMASK << (int'(w_ch) * NLEAF + int'(w_grp) * GRP);
        w_leaf_nxt = r_leaf;
        if (w_wr) w_leaf_nxt = w_wr_on ? (r_leaf | w_mask) : (r_leaf & ~w_mask);

        if (w_wr && !w_wr_on) w_chon_nxt[w_ch] = 1'b0;

        w_fin = w_wr && (w_wr_on ? (int'(w_grp) == NSTEP - 1) : (w_grp == '0));
        if (w_fin) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = (int'(w_ch) == NCH - 1) ? '0 : CHW'(int'(w_ch) + 1);
            if (w_wr_on) w_chon_nxt[w_ch] = 1'b1;
        end
    end

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_act   <= '0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_leaf  <= '0;
            r_chon  <= '0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_act   <= w_act_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_leaf  <= w_leaf_nxt;
            r_chon  <= w_chon_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign leaf_en = r_leaf;
    assign ch_on   = r_chon;
    assign busy    = r_busy;

endmodule

// File: tb/tb_bw_clk_gl_vrt_seq.sv
// Directed bench for bw_clk_gl_vrt_seq: ramp up/down, step delay, round-robin, reversal, async reset.
// Request latency tracks BW_CLK_GL_VRT_SEQ_SYNC_EN when it is defined for the build.
module tb_bw_clk_gl_vrt_seq;

    localparam int NCH   = 3;
    localparam int NLEAF = 8;
    localparam int GRP   = 2;
    localparam int DLYW  = 4;
    localparam int NW    = NCH * NLEAF;
`ifdef BW_CLK_GL_VRT_SEQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic            gclk = 1'b0;
    logic            arst_l;
    logic [NCH-1:0]  cken_req;
    logic [DLYW-1:0] step_dly;
    logic [NW-1:0]   leaf_en;
    logic [NCH-1:0]  ch_on;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] up_v  [4] = '{8'h03, 8'h0F, 8'h3F, 8'hFF};
    logic [7:0] dn_v  [4] = '{8'h3F, 8'h0F, 8'h03, 8'h00};
    logic [7:0] rev_v [11] = '{8'h03, 8'h03, 8'h03, 8'h0F, 8'h0F, 8'h0F,
                               8'h03, 8'h03, 8'h03, 8'h00, 8'h00};

    always #5 gclk = ~gclk;

    bw_clk_gl_vrt_seq #(.NCH(NCH), .NLEAF(NLEAF), .GRP(GRP), .DLYW(DLYW)) u_dut (
        .gclk     (gclk),
        .arst_l   (arst_l),
        .cken_req (cken_req),
        .step_dly (step_dly),
        .leaf_en  (leaf_en),
        .ch_on    (ch_on),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge gclk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        arst_l   = 1'b0;
        cken_req = '0;
        step_dly = '0;
        repeat (2) @(posedge gclk);
        #1;
        check({tag, "_rst_leaf"}, leaf_en, 0);
        check({tag, "_rst_chon"}, ch_on, 0);
        check({tag, "_rst_busy"}, busy, 0);
        arst_l = 1'b1;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW-1:0]  base;
        logic [NW-1:0]  chmask;
        logic [NCH-1:0] echon;

        // Basic ramp up then down on channel 0 with no step gap.
        do_reset("t1");
        step_dly = 4'd0;
        cken_req = 3'b001;
        repeat (LAT) begin
            cyc();
            check("t1_latency_leaf", leaf_en, 0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("t1_up%0d_leaf", k), leaf_en, {16'h0, up_v[k]});
            check($sformatf("t1_up%0d_busy", k), busy, (k < 3) ? 1 : 0);
            check($sformatf("t1_up%0d_chon", k), ch_on, (k == 3) ? 3'b001 : 3'b000);
        end
        cyc();
        check("t1_hold_leaf", leaf_en, {16'h0, 8'hFF});
        check("t1_hold_busy", busy, 0);
        cken_req = 3'b000;
        repeat (LAT) cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("t1_dn%0d_leaf", k), leaf_en, {16'h0, dn_v[k]});
            check($sformatf("t1_dn%0d_chon", k), ch_on, 0);
            check($sformatf("t1_dn%0d_busy", k), busy, (k < 3) ? 1 : 0);
        end

        // step_dly = 3: one group every 4 edges on channel 1.
        do_reset("t2");
        step_dly = 4'd3;
        cken_req = 3'b010;
        repeat (LAT) cyc();
        cyc();
        check("t2_start_leaf", leaf_en, {8'h00, 8'h03, 8'h00});
        for (int n = 1; n <= 12; n++) begin
            cyc();
            check($sformatf("t2_e%0d_leaf", n), leaf_en, {8'h00, up_v[n / 4], 8'h00});
            check($sformatf("t2_e%0d_chon", n), ch_on, (n == 12) ? 3'b010 : 3'b000);
        end

        // All three channels at once: ramps run ch0, ch1, ch2 round-robin.
        do_reset("t3");
        step_dly = 4'd0;
        cken_req = 3'b111;
        repeat (LAT) cyc();
        base = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < 4; k++) begin
                cyc();
                check($sformatf("t3_up_c%0d_k%0d_leaf", ch, k), leaf_en,
                      base | (NW'(up_v[k]) << (ch * NLEAF)));
                check($sformatf("t3_up_c%0d_k%0d_busy", ch, k), busy, (k < 3) ? 1 : 0);
            end
            base = base | (NW'(8'hFF) << (ch * NLEAF));
            echon = NCH'((1 << (ch + 1)) - 1);
            check($sformatf("t3_up_c%0d_chon", ch), ch_on, echon);
        end
        cken_req = 3'b000;
        repeat (LAT) cyc();
        for (int ch = 0; ch < NCH; ch++) begin
            chmask = NW'(8'hFF) << (ch * NLEAF);
            echon  = 3'b111 << (ch + 1);
            for (int k = 0; k < 4; k++) begin
                cyc();
                check($sformatf("t3_dn_c%0d_k%0d_leaf", ch, k), leaf_en,
                      (base & ~chmask) | (NW'(dn_v[k]) << (ch * NLEAF)));
                check($sformatf("t3_dn_c%0d_k%0d_chon", ch, k), ch_on, echon);
            end
            base = base & ~chmask;
        end

        // Reversal mid-ramp with step_dly = 2.
        do_reset("t4");
        step_dly = 4'd2;
        cken_req = 3'b001;
        repeat (LAT) cyc();
        for (int i = 0; i < 11; i++) begin
            cyc();
            check($sformatf("t4_e%0d_leaf", i), leaf_en, {16'h0, rev_v[i]});
            check($sformatf("t4_e%0d_busy", i), busy, (i < 9) ? 1 : 0);
            check($sformatf("t4_e%0d_chon", i), ch_on, 0);
            if (i == 3) cken_req = 3'b000;
        end

        // Asynchronous reset mid-ramp, then a clean restart.
        do_reset("t5");
        step_dly = 4'd0;
        cken_req = 3'b001;
        repeat (LAT) cyc();
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("t5_pre%0d_leaf", k), leaf_en, {16'h0, up_v[k]});
        end
        #2 arst_l = 1'b0;
        #1;
        check("t5_arst_leaf", leaf_en, 0);
        check("t5_arst_chon", ch_on, 0);
        check("t5_arst_busy", busy, 0);
        @(negedge gclk);
        arst_l = 1'b1;
        repeat (LAT) cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("t5_re%0d_leaf", k), leaf_en, {16'h0, up_v[k]});
            check($sformatf("t5_re%0d_chon", k), ch_on, (k == 3) ? 3'b001 : 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
